// File: rtl/spectrum_bank_writer_pkg.sv
// Shared spectrogram definitions: writer FSM state encoding and one-hot bank constants.
package spectrum_bank_writer_pkg;

   localparam int BANK_W = 2;

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   localparam logic [BANK_W-1:0] BANK_A = 2'b01;
   localparam logic [BANK_W-1:0] BANK_B = 2'b10;

   // With two one-hot banks the partner bank is the bit-swapped select.
   function automatic logic [BANK_W-1:0] other_bank(input logic [BANK_W-1:0] bank);
      return {bank[0], bank[1]};
   endfunction

endpackage

// File: rtl/spectrum_bank_writer.sv
// Ping-pong spectrum frame writer: fills one RAM bank while the display reads the other.
// Define SPECTRUM_BANK_WRITER_OVERWRITE_EN to overwrite the fill bank instead of stalling.
module spectrum_bank_writer
   import spectrum_bank_writer_pkg::*;
#(
   parameter int NO_BANKS   = 2,
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 4096,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_wr,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   input  logic                  rd_release,
   output logic [NO_BANKS-1:0]   wr_en,
   output logic [NO_BANKS-1:0]   wr_bank_select,
   output logic [ADDR_WIDTH-1:0] addr_wr,
   output logic [DATA_WIDTH-1:0] data_wr,
   output logic [NO_BANKS-1:0]   rd_bank_select,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic [7:0]            frames_dropped
);

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] bin_cnt;
   logic                  reader_free;
   logic                  swap_pending;
   logic                  accept;
   logic                  last_bin;
   logic                  closing;
   logic                  free_now;
   logic                  do_swap;
   logic [NO_BANKS-1:0]   wr_target;

   assign in_ready = rst_n && (state == ST_FILL);
   assign accept   = in_valid && in_ready;
   assign last_bin = (bin_cnt == ADDR_WIDTH'(DEPTH - 1));
   assign closing  = accept && (last_bin || in_last);

   // A swap already scheduled consumes the reader's release, so it cannot cover a second close.
   assign free_now = (reader_free && !swap_pending) || rd_release;
   assign do_swap  = swap_pending || ((state == ST_HOLD) && rd_release);

   // The swap lands one cycle after the closing beat so its write never targets the read bank;
   // a beat accepted during that cycle already belongs to the new fill bank.
   assign wr_target = swap_pending ? other_bank(wr_bank_select) : wr_bank_select;

   always_ff @(posedge clk_wr) begin
      if (!rst_n) begin
         state          <= ST_FILL;
         bin_cnt        <= '0;
         reader_free    <= 1'b1;
         swap_pending   <= 1'b0;
         wr_bank_select <= BANK_A;
         rd_bank_select <= BANK_B;
         wr_en          <= '0;
         addr_wr        <= '0;
         data_wr        <= '0;
         frame_done     <= 1'b0;
         frame_err      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every term above see pre-edge values.
         frame_done   <= do_swap;
         swap_pending <= closing && free_now;
         reader_free  <= do_swap ? 1'b0 : (rd_release ? 1'b1 : reader_free);
         wr_en        <= accept ? wr_target : '0;

         if (do_swap) begin
            rd_bank_select <= wr_bank_select;
            wr_bank_select <= other_bank(wr_bank_select);
         end

         if (accept) begin
            addr_wr <= bin_cnt;
            data_wr <= in_data;
            bin_cnt <= closing ? '0 : bin_cnt + ADDR_WIDTH'(1);
            if (in_last != last_bin) frame_err <= 1'b1;
         end

`ifdef SPECTRUM_BANK_WRITER_OVERWRITE_EN
         state <= ST_FILL;
`else
         if (closing && !free_now)
            state <= ST_HOLD;
         else if ((state == ST_HOLD) && rd_release)
            state <= ST_FILL;
`endif
      end
   end

`ifdef SPECTRUM_BANK_WRITER_OVERWRITE_EN
   always_ff @(posedge clk_wr) begin
      if (!rst_n)
         frames_dropped <= 8'd0;
      else if (closing && !free_now && (frames_dropped != 8'hFF))
         frames_dropped <= frames_dropped + 8'd1;
   end
`else
   assign frames_dropped = 8'd0;
`endif

endmodule

// File: tb/tb_spectrum_bank_writer.sv
// Directed bench for spectrum_bank_writer at DEPTH=16, DATA_WIDTH=4.
module tb_spectrum_bank_writer;

   logic       clk_wr = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_last;
   logic       rd_release;
   logic [1:0] wr_en;
   logic [1:0] wr_bank_select;
   logic [3:0] addr_wr;
   logic [3:0] data_wr;
   logic [1:0] rd_bank_select;
   logic       frame_done;
   logic       frame_err;
   logic [7:0] frames_dropped;

   int n_tests = 0;
   int n_fail  = 0;

   spectrum_bank_writer #(
      .NO_BANKS  (2),
      .DATA_WIDTH(4),
      .DEPTH     (16)
   ) dut (
      .clk_wr        (clk_wr),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .rd_release    (rd_release),
      .wr_en         (wr_en),
      .wr_bank_select(wr_bank_select),
      .addr_wr       (addr_wr),
      .data_wr       (data_wr),
      .rd_bank_select(rd_bank_select),
      .frame_done    (frame_done),
      .frame_err     (frame_err),
      .frames_dropped(frames_dropped)
   );

   always #5 clk_wr = ~clk_wr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_wr);
      #1;
   endtask

   // Drives n beats of data i&0xF; checks each registered write one cycle later.
   task automatic send_frame(input int n, input int last_at, input int release_at,
                             input logic [1:0] bank);
      for (int i = 0; i < n; i++) begin
         in_valid   = 1'b1;
         in_data    = 4'(i);
         in_last    = (i == last_at);
         rd_release = (i == release_at);
         step();
         check("wr_en", 32'(wr_en), 32'(bank));
         check("addr_wr", 32'(addr_wr), 32'(i));
         check("data_wr", 32'(data_wr), 32'(i & 15));
      end
      in_valid   = 1'b0;
      in_last    = 1'b0;
      rd_release = 1'b0;
   endtask

   task automatic pulse_release();
      rd_release = 1'b1;
      step();
      rd_release = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = 4'd0;
      in_last    = 1'b0;
      rd_release = 1'b0;
      step();
      step();

      // Reset state
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst wr_sel", 32'(wr_bank_select), 32'h1);
      check("rst rd_sel", 32'(rd_bank_select), 32'h2);
      check("rst wr_en", 32'(wr_en), 32'h0);
      check("rst addr", 32'(addr_wr), 32'h0);
      check("rst done", 32'(frame_done), 32'h0);
      check("rst err", 32'(frame_err), 32'h0);
      check("rst dropped", 32'(frames_dropped), 32'h0);
      rst_n = 1'b1;
      #1;
      check("in_ready after rst", 32'(in_ready), 32'd1);

      // First full frame into bank 01, swap one cycle after the last write
      send_frame(16, 15, -1, 2'b01);
      check("f1 done early", 32'(frame_done), 32'd0);
      check("f1 rd before swap", 32'(rd_bank_select), 32'h2);
      step();
      check("f1 done", 32'(frame_done), 32'd1);
      check("f1 rd_sel", 32'(rd_bank_select), 32'h1);
      check("f1 wr_sel", 32'(wr_bank_select), 32'h2);
      check("f1 wr_en idle", 32'(wr_en), 32'h0);
      step();
      check("f1 done pulse", 32'(frame_done), 32'd0);

`ifdef SPECTRUM_BANK_WRITER_OVERWRITE_EN
      // Two more frames without release: overwrite bank 10, no stall
      send_frame(16, 15, -1, 2'b10);
      check("ow2 in_ready", 32'(in_ready), 32'd1);
      step();
      check("ow2 no swap", 32'(frame_done), 32'd0);
      check("ow2 dropped", 32'(frames_dropped), 32'd1);
      send_frame(16, 15, -1, 2'b10);
      step();
      check("ow3 dropped", 32'(frames_dropped), 32'd2);
      check("ow3 rd_sel", 32'(rd_bank_select), 32'h1);
      check("ow3 wr_sel", 32'(wr_bank_select), 32'h2);
      check("ow3 err", 32'(frame_err), 32'd0);
`else
      // Second frame without release stalls in HOLD
      send_frame(16, 15, -1, 2'b10);
      check("f2 hold ready", 32'(in_ready), 32'd0);
      step();
      step();
      check("f2 hold ready2", 32'(in_ready), 32'd0);
      check("f2 hold rd_sel", 32'(rd_bank_select), 32'h1);
      check("f2 hold done", 32'(frame_done), 32'd0);
      check("dropped tied", 32'(frames_dropped), 32'd0);
      pulse_release();
      check("f2 rel rd_sel", 32'(rd_bank_select), 32'h2);
      check("f2 rel wr_sel", 32'(wr_bank_select), 32'h1);
      check("f2 rel ready", 32'(in_ready), 32'd1);
      check("f2 rel done", 32'(frame_done), 32'd1);

      // Short frame: in_last on beat 10 flags an error but still swaps
      pulse_release();
      check("err before short", 32'(frame_err), 32'd0);
      send_frame(11, 10, -1, 2'b01);
      check("short err", 32'(frame_err), 32'd1);
      step();
      check("short done", 32'(frame_done), 32'd1);
      check("short rd_sel", 32'(rd_bank_select), 32'h1);
      check("short wr_sel", 32'(wr_bank_select), 32'h2);

      // Release together with the closing beat: immediate swap, reader not free after
      send_frame(16, 15, 15, 2'b10);
      check("same-cycle ready", 32'(in_ready), 32'd1);
      step();
      check("same-cycle done", 32'(frame_done), 32'd1);
      check("same-cycle rd_sel", 32'(rd_bank_select), 32'h2);
      send_frame(16, 15, -1, 2'b01);
      check("busy reader hold", 32'(in_ready), 32'd0);
      check("err sticky", 32'(frame_err), 32'd1);
      pulse_release();
      check("busy rel rd_sel", 32'(rd_bank_select), 32'h1);

      // Reset after beat 7 discards the partial frame
      send_frame(8, -1, -1, 2'b10);
      rst_n = 1'b0;
      step();
      check("mid rst in_ready", 32'(in_ready), 32'd0);
      check("mid rst wr_en", 32'(wr_en), 32'h0);
      check("mid rst addr", 32'(addr_wr), 32'h0);
      check("mid rst data", 32'(data_wr), 32'h0);
      check("mid rst wr_sel", 32'(wr_bank_select), 32'h1);
      check("mid rst rd_sel", 32'(rd_bank_select), 32'h2);
      check("mid rst err", 32'(frame_err), 32'd0);
      check("mid rst done", 32'(frame_done), 32'd0);
      rst_n = 1'b1;
      send_frame(3, -1, -1, 2'b01);
      step();
      check("post rst no swap", 32'(frame_done), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spectrum_bank_writer.md
SPECTRUM_BANK_WRITER -- requirements
Module: spectrum_bank_writer

Interface
REQ-001 SHALL have parameter NO_BANKS, default 2: number of RAM banks; only 2 is supported.
REQ-002 SHALL have parameter DATA_WIDTH, default 4: width of one spectrum bin.
REQ-003 SHALL have parameter DEPTH, default 4096: bins per frame, which is also the bank depth; ADDR_WIDTH = $clog2(DEPTH).
REQ-004 SHALL have port clk_wr, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: an upstream bin is present.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a bin this cycle.
REQ-008 SHALL have port in_data, input, DATA_WIDTH bits: bin magnitude.
REQ-009 SHALL have port in_last, input, 1 bit: upstream end-of-frame marker.
REQ-010 SHALL have port rd_release, input, 1 bit: pulse from the display reader when it is done with the current read bank.
REQ-011 SHALL have port wr_en, output, NO_BANKS bits: per-bank write strobe.
REQ-012 SHALL have port wr_bank_select, output, NO_BANKS bits: one-hot write bank.
REQ-013 SHALL have port addr_wr, output, ADDR_WIDTH bits: write address.
REQ-014 SHALL have port data_wr, output, DATA_WIDTH bits: write data.
REQ-015 SHALL have port rd_bank_select, output, NO_BANKS bits: one-hot bank the reader shall display.
REQ-016 SHALL have port frame_done, output, 1 bit: one-cycle pulse on each bank swap.
REQ-017 SHALL have port frame_err, output, 1 bit: sticky framing-error flag.
REQ-018 SHALL have port frames_dropped, output, 8 bits: count of overwritten frames.

Function
REQ-019 SHALL use states FILL and HOLD; a beat is accepted when in_valid && in_ready; in_ready = (state==FILL).
REQ-020 SHALL register every write-side output: for an accepted beat at cycle N, the cycle N+1 outputs are wr_en = wr_bank_select, addr_wr = beat index, data_wr = in_data; otherwise wr_en = 0.
REQ-021 SHALL keep an internal bin counter starting at 0 and incrementing per accepted beat; the frame closes on a beat with counter==DEPTH-1 or on in_last, whichever comes first; the counter then returns to 0.
REQ-022 SHALL set frame_err when in_last arrives with counter != DEPTH-1, or when counter==DEPTH-1 is reached without in_last; frame_err is cleared only by reset.
REQ-023 SHALL keep internal flag reader_free, set by rd_release and cleared by a swap; a simultaneous swap and rd_release SHALL leave it cleared.
REQ-024 SHALL, on frame close with reader_free=1 or rd_release=1 in the same cycle, swap next cycle: rd_bank_select <= wr_bank_select, wr_bank_select <= other bank, frame_done=1, and remain in FILL.
REQ-025 SHALL, on frame close with reader_free=0, enter HOLD with in_ready=0; on rd_release in HOLD it SHALL swap per REQ-024 next cycle and return to FILL.
REQ-026 SHALL always write the last beat of a frame before, or in the same cycle as, the swap takes effect on rd_bank_select.
REQ-027 SHALL never assert wr_en on the bank currently selected by rd_bank_select.

Reset
REQ-028 SHALL, with rst_n=0 at a clock edge, set state=FILL, counter=0, wr_bank_select=01, rd_bank_select=10, reader_free=1, wr_en=0, addr_wr=0, data_wr=0, frame_done=0, frame_err=0, frames_dropped=0.
REQ-029 SHALL, on reset mid-frame, discard the partial frame without a swap; in_ready is 0 during reset.

Configuration
REQ-030 SHALL, with SPECTRUM_BANK_WRITER_OVERWRITE_EN defined, replace HOLD behaviour: a frame close with reader_free=0 restarts filling the same bank at address 0 with no stall, and increments frames_dropped, saturating at 255.
REQ-031 SHALL, without SPECTRUM_BANK_WRITER_OVERWRITE_EN, stall in HOLD per REQ-025, with frames_dropped tied to 0.

Structure
REQ-032 SHALL take the state enum encoding and the default ONE_HOT bank constants 2'b01 and 2'b10 from the shared spectrogram package.
REQ-033 SHALL be a single module with no sub-modules; the bin counter is inline.

Verification (DEPTH=16, DATA_WIDTH=4)
REQ-034 SHALL cover: reset, then 16 beats of data i&0xF with in_last on the 16th -> writes to bank 01 at addresses 0..15, frame_done at the cycle after the last write, rd_bank_select=01, wr_bank_select=10.
REQ-035 SHALL cover: a second 16-beat frame with no rd_release -> HOLD, in_ready=0; rd_release at cycle T -> rd_bank_select=10 at T+1 and in_ready=1.
REQ-036 SHALL cover: in_last on beat 10 -> frame_err=1, swap occurs, the next frame starts at address 0.
REQ-037 SHALL cover: rd_release in the same cycle as the closing beat -> swap with no HOLD cycle, and reader_free=0 afterwards.
REQ-038 SHALL cover: rst_n=0 after beat 7 -> all outputs at reset values, and the next frame writes bank 01 from address 0.
REQ-039 SHALL cover, with OVERWRITE_EN: three frames with no rd_release -> no stall, frames_dropped=2, rd_bank_select unchanged after the first swap.
